// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS sequencing controller.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    RESET    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    ADDIEX   = 4'd11,
    ADDIWB   = 4'd12,
    HALT     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full datapath control word produced for one state.
  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Opcode/handshake inputs and datapath control outputs of the sequencing controller.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic [1:0] PCSource;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcB;
  logic       ALUSrcA;
  logic       RegWrite;
  logic       RegDst;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// State to control-word decode; only FETCH/MEMWRITE look at mem_ready, only DECODE at op.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Per-state control word; anything not set stays 0 (RESET, HALT, illegal encodings).
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.MemRead  = 1'b1;
        ctrl_o.ALUSrcB  = SRCB_FOUR;
        ctrl_o.ALUOp    = ALUOP_ADD;
        ctrl_o.PCSource = PCSRC_ALU;
        ctrl_o.IRWrite  = mem_ready_i;
        ctrl_o.PCWrite  = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.ALUSrcB    = SRCB_IMMSH;
        ctrl_o.ALUOp      = ALUOP_ADD;
        ctrl_o.illegal_op = !op_supported(op_i);
      end
      MEMADR, ADDIEX: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_IMM;
        ctrl_o.ALUOp   = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl_o.MemRead = 1'b1;
        ctrl_o.IorD    = 1'b1;
      end
      MEMWB: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.MemtoReg   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl_o.MemWrite   = 1'b1;
        ctrl_o.IorD       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      EXECUTE: begin
        ctrl_o.ALUSrcA = 1'b1;
        ctrl_o.ALUSrcB = SRCB_B;
        ctrl_o.ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.RegDst     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_o.ALUSrcA     = 1'b1;
        ctrl_o.ALUSrcB     = SRCB_B;
        ctrl_o.ALUOp       = ALUOP_SUB;
        ctrl_o.PCWriteCond = 1'b1;
        ctrl_o.PCSource    = PCSRC_ALUOUT;
        ctrl_o.instr_done  = 1'b1;
      end
      JUMP: begin
        ctrl_o.PCWrite    = 1'b1;
        ctrl_o.PCSource   = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl_o.RegWrite   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencer: state register and next-state logic; outputs decoded from state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W      = 4,
  parameter bit          ILLEGAL_TRAP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus,
  output logic [STATE_W-1:0]   state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // Next-state selection; unreachable encodings fall back to RESET.
  always_comb begin
    state_d = RESET;
    case (state_q)
      RESET:    state_d = FETCH;
      FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEMADR:   state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = bus.mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = bus.mem_ready ? FETCH : MEMWRITE;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      ADDIEX:   state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = RESET;
    endcase
  end

  // State register; async reset forces RESET, which decodes to all-zero outputs immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET;
    else        state_q <= state_d;
  end

  mc_output_decode u_decode (
    .state_i     (state_q),
    .op_i        (bus.op),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.PCWrite     = ctrl.PCWrite;
  assign bus.PCWriteCond = ctrl.PCWriteCond;
  assign bus.IorD        = ctrl.IorD;
  assign bus.MemRead     = ctrl.MemRead;
  assign bus.MemWrite    = ctrl.MemWrite;
  assign bus.IRWrite     = ctrl.IRWrite;
  assign bus.MemtoReg    = ctrl.MemtoReg;
  assign bus.PCSource    = ctrl.PCSource;
  assign bus.ALUOp       = ctrl.ALUOp;
  assign bus.ALUSrcB     = ctrl.ALUSrcB;
  assign bus.ALUSrcA     = ctrl.ALUSrcA;
  assign bus.RegWrite    = ctrl.RegWrite;
  assign bus.RegDst      = ctrl.RegDst;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.illegal_op  = ctrl.illegal_op;

  assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: expected per-cycle traces built from per-opcode state paths.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    state_t     st;
    logic [5:0] op;
    logic       mr;
    ctl_t       c;
  } step_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] st0, st1;
  ctl_t       o0, o1;
  int         checks = 0;
  int         errors = 0;
  step_t      q[$];

  multicycle_control_if b0();
  multicycle_control_if b1();
  assign b1.op        = b0.op;
  assign b1.mem_ready = b0.mem_ready;

  multicycle_control #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .state_o(st0));
  multicycle_control #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .state_o(st1));

  assign o0 = {b0.PCWrite, b0.PCWriteCond, b0.IorD, b0.MemRead, b0.MemWrite, b0.IRWrite,
               b0.MemtoReg, b0.PCSource, b0.ALUOp, b0.ALUSrcB, b0.ALUSrcA, b0.RegWrite,
               b0.RegDst, b0.instr_done, b0.illegal_op};
  assign o1 = {b1.PCWrite, b1.PCWriteCond, b1.IorD, b1.MemRead, b1.MemWrite, b1.IRWrite,
               b1.MemtoReg, b1.PCSource, b1.ALUOp, b1.ALUSrcB, b1.ALUSrcA, b1.RegWrite,
               b1.RegDst, b1.instr_done, b1.illegal_op};

  always #5 clk = ~clk;

  // Control word each state should show, straight from the state table.
  function automatic ctl_t exp_ctl(input state_t s, input logic mr, input logic [5:0] opc);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.MemRead = 1'b1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.PCWrite = mr; end
      DECODE:   begin
        c.ALUSrcB    = 2'b11;
        c.illegal_op = !(opc inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
      end
      MEMADR:   begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      MEMREAD:  begin c.MemRead = 1'b1; c.IorD = 1'b1; end
      MEMWB:    begin c.RegWrite = 1'b1; c.MemtoReg = 1'b1; c.instr_done = 1'b1; end
      MEMWRITE: begin c.MemWrite = 1'b1; c.IorD = 1'b1; c.instr_done = mr; end
      EXECUTE:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b10; end
      ALUWB:    begin c.RegWrite = 1'b1; c.RegDst = 1'b1; c.instr_done = 1'b1; end
      BRANCH:   begin
        c.ALUSrcA = 1'b1; c.ALUOp = 2'b01; c.PCWriteCond = 1'b1;
        c.PCSource = 2'b01; c.instr_done = 1'b1;
      end
      JUMP:     begin c.PCWrite = 1'b1; c.PCSource = 2'b10; c.instr_done = 1'b1; end
      ADDIEX:   begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
      ADDIWB:   begin c.RegWrite = 1'b1; c.instr_done = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void add(input state_t s, input logic mr, input logic [5:0] opc);
    step_t st;
    st.st = s; st.op = opc; st.mr = mr; st.c = exp_ctl(s, mr, opc);
    q.push_back(st);
  endfunction

  // One instruction: wf fetch wait cycles, wm memory wait cycles, then the opcode's path.
  function automatic void model_instr(input logic [5:0] opc, input int unsigned wf,
                                      input int unsigned wm);
    for (int unsigned i = 0; i < wf; i++) add(FETCH, 1'b0, opc);
    add(FETCH, 1'b1, opc);
    add(DECODE, rnd1(), opc);
    case (opc)
      6'h23: begin
        add(MEMADR, rnd1(), opc);
        for (int unsigned i = 0; i < wm; i++) add(MEMREAD, 1'b0, opc);
        add(MEMREAD, 1'b1, opc);
        add(MEMWB, rnd1(), opc);
      end
      6'h2B: begin
        add(MEMADR, rnd1(), opc);
        for (int unsigned i = 0; i < wm; i++) add(MEMWRITE, 1'b0, opc);
        add(MEMWRITE, 1'b1, opc);
      end
      6'h00: begin add(EXECUTE, rnd1(), opc); add(ALUWB, rnd1(), opc); end
      6'h04: add(BRANCH, rnd1(), opc);
      6'h02: add(JUMP, rnd1(), opc);
      6'h08: begin add(ADDIEX, rnd1(), opc); add(ADDIWB, rnd1(), opc); end
      default: ;
    endcase
  endfunction

  task automatic apply(input step_t s);
    b0.op = s.op; b0.mem_ready = s.mr; #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    b0.op = 6'h23; b0.mem_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st0 !== RESET || o0 !== '0 || st1 !== RESET || o1 !== '0) begin
        errors++;
        $display("FAIL reset_hold: st0=%0d ctl0=%h st1=%0d ctl1=%h expected st=0 ctl=0",
                 st0, o0, st1, o1);
      end
      @(posedge clk); #2; b0.mem_ready = rnd1();
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lw();
    step_t s;
    add(RESET, 1'b1, 6'h23);
    model_instr(6'h23, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s);
      checks++;
      if (st0 !== s.st || o0 !== s.c) begin
        errors++;
        $display("FAIL lw_seq: state=%0d ctl=%h expected state=%0d ctl=%h", st0, o0, s.st, s.c);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw_wait();
    step_t s;
    int    wr_cycles = 0;
    model_instr(6'h2B, 0, 3);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s);
      wr_cycles += int'(o0.MemWrite);
      checks++;
      if (st0 !== s.st || o0 !== s.c) begin
        errors++;
        $display("FAIL sw_wait: state=%0d ctl=%h expected state=%0d ctl=%h", st0, o0, s.st, s.c);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (wr_cycles != 4 || st0 !== FETCH) begin
      errors++;
      $display("FAIL sw_hold: memwrite_cycles=%0d state=%0d expected 4 and state=%0d",
               wr_cycles, st0, FETCH);
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    model_instr(6'h00, 0, 0);
    model_instr(6'h04, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s);
      checks++;
      if (st0 !== s.st || o0 !== s.c) begin
        errors++;
        $display("FAIL r_beq: state=%0d ctl=%h expected state=%0d ctl=%h", st0, o0, s.st, s.c);
      end
      next_cycle();
    end
  endtask

  task automatic test_fetch_wait();
    step_t s;
    int    ir_loads = 0;
    model_instr(6'h08, 2, 0);
    model_instr(6'h02, 1, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s);
      ir_loads += int'(o0.IRWrite);
      checks++;
      if (st0 !== s.st || o0 !== s.c) begin
        errors++;
        $display("FAIL fetch_wait: state=%0d ctl=%h expected state=%0d ctl=%h", st0, o0, s.st, s.c);
      end
      next_cycle();
    end
    checks++;
    if (ir_loads != 2) begin
      errors++;
      $display("FAIL ir_loads: got %0d expected 2", ir_loads);
    end
  endtask

  task automatic test_random();
    step_t      s;
    logic [5:0] ops [6];
    logic [5:0] opc;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h02; ops[5] = 6'h08;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 6) == 6) opc = 6'($urandom_range(0, 63));
      else                           opc = ops[$urandom_range(0, 5)];
      model_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s);
      checks++;
      if (st0 !== s.st || o0 !== s.c) begin
        errors++;
        $display("FAIL random: op=%h state=%0d ctl=%h expected state=%0d ctl=%h",
                 s.op, st0, o0, s.st, s.c);
      end
      checks++;
      if ((o0.MemRead && o0.MemWrite) || (o0.RegWrite && (o0.PCWrite || o0.PCWriteCond))) begin
        errors++;
        $display("FAIL exclusive: ctl=%h expected no read+write and no regwrite+pcwrite", o0);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    b0.op = 6'h3F; b0.mem_ready = 1'b1; #1;
    next_cycle(); #1;
    checks++;
    if (st0 !== FETCH || st1 !== FETCH) begin
      errors++;
      $display("FAIL ill_fetch: st0=%0d st1=%0d expected %0d", st0, st1, FETCH);
    end
    next_cycle(); #1;
    checks++;
    if (st0 !== DECODE || o0.illegal_op !== 1'b1 || st1 !== DECODE || o1.illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL ill_pulse: st0=%0d ill0=%b st1=%0d ill1=%b expected state=%0d ill=1",
               st0, o0.illegal_op, st1, o1.illegal_op, DECODE);
    end
    next_cycle(); #1;
    checks++;
    if (st0 !== FETCH || o0.illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL ill_return: st0=%0d ill0=%b expected state=%0d ill=0", st0, o0.illegal_op, FETCH);
    end
    for (int i = 0; i < 4; i++) begin
      b0.mem_ready = rnd1(); b0.op = 6'($urandom_range(0, 63)); #1;
      checks++;
      if (st1 !== HALT || o1 !== '0) begin
        errors++;
        $display("FAIL halt_hold: st1=%0d ctl1=%h expected state=%0d ctl=0", st1, o1, HALT);
      end
      next_cycle();
    end
    rst_n = 1'b0; #1;
    checks++;
    if (st1 !== RESET || o1 !== '0) begin
      errors++;
      $display("FAIL halt_reset: st1=%0d ctl1=%h expected state=0 ctl=0", st1, o1);
    end
    next_cycle(); rst_n = 1'b1; b0.mem_ready = 1'b0; #1;
    next_cycle(); #1;
    checks++;
    if (st1 !== FETCH || o1.MemRead !== 1'b1) begin
      errors++;
      $display("FAIL halt_restart: st1=%0d memread=%b expected state=%0d memread=1",
               st1, o1.MemRead, FETCH);
    end
  endtask

  task automatic test_reset_midread();
    step_t s;
    do_reset();
    add(RESET, 1'b1, 6'h23);
    add(FETCH, 1'b1, 6'h23);
    add(DECODE, 1'b1, 6'h23);
    add(MEMADR, 1'b1, 6'h23);
    add(MEMREAD, 1'b0, 6'h23);
    while (q.size() > 0) begin
      s = q.pop_front(); apply(s);
      checks++;
      if (st0 !== s.st || o0 !== s.c) begin
        errors++;
        $display("FAIL pre_abort: state=%0d ctl=%h expected state=%0d ctl=%h", st0, o0, s.st, s.c);
      end
      if (q.size() > 0) next_cycle();
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (st0 !== RESET || o0 !== '0) begin
      errors++;
      $display("FAIL async_abort: state=%0d ctl=%h expected state=0 ctl=0", st0, o0);
    end
    next_cycle(); rst_n = 1'b1; #1;
    checks++;
    if (st0 !== RESET || o0 !== '0) begin
      errors++;
      $display("FAIL post_release: state=%0d ctl=%h expected state=0 ctl=0", st0, o0);
    end
    next_cycle(); #1;
    checks++;
    if (st0 !== FETCH || o0 !== exp_ctl(FETCH, 1'b0, 6'h23)) begin
      errors++;
      $display("FAIL restart_fetch: state=%0d ctl=%h expected state=%0d", st0, o0, FETCH);
    end
  endtask

  initial begin
    b0.op = '0; b0.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_fetch_wait();
    test_random();
    test_illegal();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
